// File: rtl/md_unit_ctrl.sv
// rtl/md_unit_ctrl.sv - multi-cycle multiply/divide unit with HI/LO registers (optional madd-class ops under MD_MADD_EN)
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic        decode_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] read_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic        madd_op;
  logic        start_mul;
  logic        start_div;

  logic [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] abs_a, abs_b;
  logic [31:0] dnd, dsr, dsr_safe;
  logic [31:0] uq, ur;
  logic [31:0] sq, sr;
  logic        res_we;
  logic [31:0] res_hi, res_lo;

  // Accumulating ops only count as long ops when the feature is built in;
  // otherwise they fall through as no-ops.
`ifdef MD_MADD_EN
  assign madd_op = (op == OP_MADD) || (op == OP_MADDU) ||
                   (op == OP_MSUB) || (op == OP_MSUBU);
`else
  assign madd_op = 1'b0;
`endif

  assign start_mul = (op == OP_MULT) || (op == OP_MULTU) || madd_op;
  assign start_div = (op == OP_DIV) || (op == OP_DIVU);

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = decode_md_use && (busy_q || (start && (start_mul || start_div)));

  // Move-from reads see the registers directly, so a commit on the previous edge is visible.
  always_comb begin
    read_data = 32'd0;
    if (start && (op == OP_MFHI)) read_data = hi_q;
    if (start && (op == OP_MFLO)) read_data = lo_q;
  end

  // Arithmetic on latched operands; signed division is done on magnitudes so
  // that 0x80000000 / -1 wraps to 0x80000000 without overflow trouble.
  always_comb begin
    a_sx       = {{32{a_q[31]}}, a_q};
    b_sx       = {{32{b_q[31]}}, b_q};
    prod_s     = a_sx * b_sx;
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == OP_DIV);
    abs_a      = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b      = b_q[31] ? (32'd0 - b_q) : b_q;
    dnd        = div_signed ? abs_a : a_q;
    dsr        = div_signed ? abs_b : b_q;
    dsr_safe   = (dsr == 32'd0) ? 32'd1 : dsr;
    uq         = dnd / dsr_safe;
    ur         = dnd % dsr_safe;
    sq         = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
    sr         = a_q[31] ? (32'd0 - ur) : ur;
  end

  // Select the HI/LO values written when the countdown expires.
  always_comb begin
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_we = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_hi = ur;
          res_lo = uq;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD:  begin res_we = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin res_we = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin res_we = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin res_we = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} - prod_u; end
`endif
      default: res_we = 1'b0;
    endcase
  end

  // Next-state: accept ops only in IDLE, count down in RUN and commit on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        if (start_mul || start_div) begin
          op_d    = op;
          a_d     = src0;
          b_d     = src1;
          cnt_d   = start_div ? DIV_CNT : MULT_CNT;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (op == OP_MTHI) begin
          hi_d = src0;
        end else if (op == OP_MTLO) begin
          lo_d = src0;
        end
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (res_we) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb/tb_md_unit_ctrl.sv - directed self-checking bench for md_unit_ctrl
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        decode_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] read_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  int n;

  md_unit_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .op            (op),
    .src0          (src0),
    .src1          (src1),
    .decode_md_use (decode_md_use),
    .busy          (busy),
    .stall_req     (stall_req),
    .read_data     (read_data),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src0  = a;
    src1  = b;
    tick();
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    op            = 4'd0;
    src0          = 32'd0;
    src1          = 32'd0;
    decode_md_use = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_stall", stall_req, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // mult -2 * 3
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    busy_len(n);
    check("mult_busy_len", n, 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // divu 100 / 7
    issue(4'd4, 32'd100, 32'd7);
    busy_len(n);
    check("divu_busy_len", n, 10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // div -7 / 2
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    busy_len(n);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    // preset hi/lo, mthi, then divide by zero
    issue(4'd7, 32'd5, 32'd0);
    issue(4'd8, 32'd6, 32'd0);
    check("mthi_hi", hi, 32'd5);
    check("mtlo_lo", lo, 32'd6);
    issue(4'd7, 32'h1234, 32'd0);
    issue(4'd3, 32'd9, 32'd0);
    busy_len(n);
    check("div0_busy_len", n, 10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'd6);

    // most-negative / -1
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    busy_len(n);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'd0);

    // stall coverage of start cycle plus busy, starts during RUN ignored
    decode_md_use = 1'b1;
    start = 1'b1;
    op    = 4'd1;
    src0  = 32'd3;
    src1  = 32'd4;
    #1;
    check("stall_start_cycle", stall_req, 1);
    check("busy_start_cycle", busy, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2) || (i == 3);
      op    = (i == 2) ? 4'd7 : ((i == 3) ? 4'd3 : 4'd0);
      src0  = 32'hDEAD;
      src1  = 32'd1;
      #1;
      check($sformatf("stall_busy_%0d", i), {busy, stall_req}, 2'b11);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    op    = 4'd0;
    #1;
    check("busy_after_5", busy, 0);
    check("stall_after_busy", stall_req, 0);
    start = 1'b1;
    op    = 4'd6;
    #1;
    check("mflo_read", read_data, 32'd12);
    check("mflo_stall", stall_req, 0);
    op = 4'd5;
    #1;
    check("mfhi_read", read_data, 32'd0);
    op = 4'd0;
    #1;
    check("none_read", read_data, 32'd0);
    tick();
    start = 1'b0;
    decode_md_use = 1'b0;

    // async reset during multu busy cycle 3
    issue(4'd2, 32'd7, 32'd9);
    tick();
    tick();
    check("multu_busy_c3", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    busy_len(n);
    check("multu_after_reset_len", n, 5);
    check("multu_after_reset_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    // maddu 1*1 onto hi=0, lo=FFFFFFFF
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0);
    decode_md_use = 1'b1;
    start = 1'b1;
    op    = 4'd10;
    src0  = 32'd1;
    src1  = 32'd1;
    #1;
`ifdef MD_MADD_EN
    check("maddu_stall", stall_req, 1);
`else
    check("maddu_stall", stall_req, 0);
`endif
    tick();
    start = 1'b0;
    op    = 4'd0;
    decode_md_use = 1'b0;
    busy_len(n);
`ifdef MD_MADD_EN
    check("maddu_busy_len", n, 5);
    check("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
`else
    check("maddu_busy_len", n, 0);
    check("maddu_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // undefined and none ops have no effect
    issue(4'd7, 32'hAAAA, 32'd0);
    issue(4'd15, 32'h5555, 32'd3);
    check("op15_busy", busy, 0);
    issue(4'd0, 32'h5555, 32'd3);
    check("op0_busy", busy, 0);
    check("op15_hi", hi, 32'hAAAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
